decoded_instr_queue: RTL

- Parametrised, multi-lane, in-order FIFO of `decode_pkg::decode_data_t` entries.
- Sits between the decode stage and issue, so decode and issue can run at different widths and stall independently.
- Generalises the single decoded-instruction slot to IN_WIDTH enqueue lanes, OUT_WIDTH dequeue lanes and DEPTH entries.
- Adds two behaviours: pipeline flush, and delay-slot pairing so a branch never issues without its delay slot.

---
 rtl/decoded_instr_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decoded_instr_queue.sv
// decoded_instr_queue: multi-lane in-order FIFO of decoded instructions
// between decode and issue. It accepts up to IN_WIDTH entries per cycle and
// presents up to OUT_WIDTH entries per cycle, oldest entry on lane 0.
// A branch or jump is never presented without its delay slot.
// flush empties the queue at the next edge.
// Optional feature: define DECODED_INSTR_QUEUE_BYPASS_EN to present input
// lanes in the same cycle when the queue is empty.

package decode_pkg;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       jr;
        logic [3:0] alu_op;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        ctl_t        ctl;
    } decode_data_t;

endpackage

module decoded_instr_queue
    import decode_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 flush,
    input  decode_data_t [IN_WIDTH-1:0]          in_data,
    output logic                                 in_ready,
    output decode_data_t [OUT_WIDTH-1:0]         out_data,
    input  logic [$clog2(OUT_WIDTH+1)-1:0]       out_take,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic                                 empty,
    output logic                                 full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(OUT_WIDTH+1);
    localparam int KW = $clog2(IN_WIDTH+1);

    decode_data_t mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;

    logic [KW-1:0] in_k;
    logic [KW-1:0] wr_k;
    logic [TW-1:0] wr_ofs;
    logic [TW-1:0] deq;
    logic [TW-1:0] avail;
    logic [TW-1:0] presented;
    logic          bypass_act;
    decode_data_t  cand    [OUT_WIDTH];
    decode_data_t  wr_lane [IN_WIDTH];

    // Acceptance is judged only on the registered count; a same-cycle
    // dequeue gives no credit.
    always_comb begin : ready_calc
        in_ready = (CW'(DEPTH) - cnt) >= CW'(IN_WIDTH);
        count    = cnt;
        empty    = (cnt == '0);
        full     = (cnt == CW'(DEPTH));
    end

    // Count the valid input lanes. Valid lanes are contiguous from lane 0.
    always_comb begin : lane_count
        in_k = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (in_data[i].valid && in_k == KW'(i)) in_k = KW'(i + 1);
        end
    end

    // Candidate entries come from storage. In bypass mode an empty queue
    // takes its candidates from the input lanes instead.
    always_comb begin : candidates
        bypass_act = 1'b0;
        for (int i = 0; i < OUT_WIDTH; i++) cand[i] = mem[head + PW'(i)];
        avail = (int'(cnt) >= OUT_WIDTH) ? TW'(OUT_WIDTH) : TW'(cnt);
`ifdef DECODED_INSTR_QUEUE_BYPASS_EN
        if (cnt == '0 && in_ready) begin
            bypass_act = 1'b1;
            for (int i = 0; i < OUT_WIDTH; i++) begin
                cand[i] = '0;
                for (int j = 0; j < IN_WIDTH; j++) begin
                    if (j == i) cand[i] = in_data[j];
                end
            end
            avail = (int'(in_k) >= OUT_WIDTH) ? TW'(OUT_WIDTH) : TW'(in_k);
        end
`endif
    end

    // Withhold a trailing control-transfer entry until its delay slot is
    // also a candidate. The delay slot of the last candidate always lies
    // outside the candidate window, so a trailing branch is always held back.
    always_comb begin : pairing
        presented = avail;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (TW'(i + 1) == avail &&
                (cand[i].ctl.branch || cand[i].ctl.jump || cand[i].ctl.jr))
                presented = avail - TW'(1);
        end
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_data[i]       = cand[i];
            out_data[i].valid = (TW'(i) < presented);
        end
    end

    // Work out how many lanes are written and how many stored entries are
    // retired. Lanes consumed through bypass are not written to storage.
    always_comb begin : write_ctl
        wr_ofs = '0;
        wr_k   = in_ready ? in_k : '0;
        deq    = out_take;
`ifdef DECODED_INSTR_QUEUE_BYPASS_EN
        if (bypass_act) begin
            wr_ofs = out_take;
            wr_k   = in_k - KW'(out_take);
            deq    = '0;
        end
`endif
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_lane[i] = '0;
            for (int j = 0; j < IN_WIDTH; j++) begin
                if (j == i + int'(wr_ofs)) wr_lane[i] = in_data[j];
            end
        end
    end

    // Update the pointers and count. flush overrides enqueue and dequeue.
    always_ff @(posedge clk or negedge resetn) begin : ptr_regs
        if (!resetn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            head <= head + PW'(deq);
            tail <= tail + PW'(wr_k);
            cnt  <= cnt + CW'(wr_k) - CW'(deq);
        end
    end

    // Write storage. The data array has no reset because occupancy comes
    // entirely from the count and pointers.
    always_ff @(posedge clk) begin : mem_write
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (resetn && !flush && KW'(i) < wr_k) mem[tail + PW'(i)] <= wr_lane[i];
        end
    end

    // Issue must never take more entries than are presented.
    take_le_presented: assert property (
        @(posedge clk) disable iff (!resetn || flush) out_take <= presented
    );

endmodule
